// File: rtl/knap18_search.sv
// knap18_search: exhaustive 0/1 knapsack search over an 18-item table.
//
// Every subset sel = 0..2^18-1 is issued once, in ascending order. A
// two-stage pipeline totals value/weight/volume for each subset and then
// tracks the hit count and the best feasible subset.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   item_we, item_idx             table write strobe/index (IDLE only, idx < 18)
//   item_val, item_wt, item_vol   entry contents
//   start, abort                  begin search (IDLE only) / cancel search
//   busy, done                    RUN|DRAIN flag, one-cycle completion pulse
//   found, hit_count              any hit seen / number of hits
//   best_sel, best_value          best feasible subset and its total value

module knap18_term (
    input  logic       sel,
    input  logic [7:0] val,
    input  logic [7:0] wt,
    input  logic [7:0] vol,
    output logic [7:0] m_val,
    output logic [7:0] m_wt,
    output logic [7:0] m_vol
);
    assign m_val = sel ? val : '0;
    assign m_wt  = sel ? wt  : '0;
    assign m_vol = sel ? vol : '0;
endmodule

module knap18_search #(
    parameter int MIN_VALUE  = 120,
    parameter int MAX_WEIGHT = 60,
    parameter int MAX_VOLUME = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        item_we,
    input  logic [4:0]  item_idx,
    input  logic [7:0]  item_val,
    input  logic [7:0]  item_wt,
    input  logic [7:0]  item_vol,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [18:0] hit_count,
    output logic [17:0] best_sel,
    output logic [12:0] best_value
);
    localparam int          NUM_ITEMS = 18;
    localparam int          STAGES    = 1;
    localparam logic [17:0] LAST_SEL  = '1;
    localparam logic [12:0] MINV      = 13'(MIN_VALUE);
    localparam logic [12:0] MAXW      = 13'(MAX_WEIGHT);
    localparam logic [12:0] MAXO      = 13'(MAX_VOLUME);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nx;
    logic   drain_cnt;

    logic [NUM_ITEMS-1:0][7:0] tab_val, tab_wt, tab_vol;
    logic [NUM_ITEMS-1:0][7:0] m_val, m_wt, m_vol;

    logic [17:0]     cnt;       // next subset to issue
    logic [17:0]     iss_sel;   // issued subset, feeds the adders
    logic [17:0]     s1_sel;
    logic [12:0]     s1_val, s1_wt, s1_vol;
    logic [12:0]     sum_val, sum_wt, sum_vol;
    logic [STAGES:0] vld_pipe;  // [0] issue, [1] stage 1

    logic start_acc, flush, s1_feas;

    assign busy      = (state == RUN) || (state == DRAIN);
    assign done      = (state == DONE);
    assign start_acc = (state == IDLE) && start;
    assign flush     = busy && abort;
    assign s1_feas   = (s1_wt <= MAXW) && (s1_vol <= MAXO);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nx;
            drain_cnt <= (state == DRAIN) ? 1'b1 : 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = RUN;
            RUN:   if (abort) state_nx = IDLE;
                   else if (cnt == LAST_SEL) state_nx = DRAIN;
            DRAIN: if (abort) state_nx = IDLE;
                   else if (drain_cnt) state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- per-item masking and totals ----------------
    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_term
        knap18_term u_term (
            .sel  (iss_sel[g]),
            .val  (tab_val[g]),
            .wt   (tab_wt[g]),
            .vol  (tab_vol[g]),
            .m_val(m_val[g]),
            .m_wt (m_wt[g]),
            .m_vol(m_vol[g])
        );
    end

    // 18 * 255 = 4590 fits in 13 bits, so no total can overflow.
    always_comb begin
        sum_val = '0;
        sum_wt  = '0;
        sum_vol = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            sum_val = sum_val + 13'(m_val[i]);
            sum_wt  = sum_wt  + 13'(m_wt[i]);
            sum_vol = sum_vol + 13'(m_vol[i]);
        end
    end

    // ---------------- table, pipeline, results ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tab_val    <= '0;
            tab_wt     <= '0;
            tab_vol    <= '0;
            cnt        <= '0;
            iss_sel    <= '0;
            s1_sel     <= '0;
            s1_val     <= '0;
            s1_wt      <= '0;
            s1_vol     <= '0;
            vld_pipe   <= '0;
            found      <= 1'b0;
            hit_count  <= '0;
            best_sel   <= '0;
            best_value <= '0;
        end else begin
            if ((state == IDLE) && item_we && (item_idx < 5'(NUM_ITEMS))) begin
                tab_val[item_idx] <= item_val;
                tab_wt[item_idx]  <= item_wt;
                tab_vol[item_idx] <= item_vol;
            end

            // issue stage
            if (start_acc)          cnt <= '0;
            else if (state == RUN)  cnt <= cnt + 18'd1;
            iss_sel     <= cnt;
            vld_pipe[0] <= (state == RUN) && !abort;

            // stage 1: register subset with its totals
            vld_pipe[1] <= vld_pipe[0] && !flush;
            s1_sel      <= iss_sel;
            s1_val      <= sum_val;
            s1_wt       <= sum_wt;
            s1_vol      <= sum_vol;

            // stage 2: strict > keeps the lower sel on ties (ascending issue)
            if (start_acc) begin
                found      <= 1'b0;
                hit_count  <= '0;
                best_sel   <= '0;
                best_value <= '0;
            end else if (vld_pipe[1] && !flush && s1_feas) begin
                if (s1_val >= MINV) begin
                    hit_count <= hit_count + 19'd1;
                    found     <= 1'b1;
                end
                if (s1_val > best_value) begin
                    best_sel   <= s1_sel;
                    best_value <= s1_val;
                end
            end
        end
    end
endmodule
